// File: rtl/weight_bank_streamer.sv
// weight_bank_streamer: captures loader writes into a small register bank and
// streams the bank in slot order over valid/ready once started, then pulses done.
module weight_bank_streamer #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              busy,
    output logic              done,
    output logic [DEPTH-1:0]  loaded,
    output logic              wr_err,
    output logic              start_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [WORD_W-1:0] bank   [DEPTH];
    logic [WORD_W-1:0] bank_n [DEPTH];
    logic [DEPTH-1:0]  loaded_n;
    logic              wr_err_n, start_err_n;
    logic              out_valid_n, busy_n, done_n;
    logic [WORD_W-1:0] out_data_n;
    logic [ADDR_W-1:0] out_index_n;

    // Next-state, bank update and next-output decode; outputs are registered from these.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        loaded_n    = loaded;
        wr_err_n    = wr_err;
        start_err_n = start_err;
        for (int i = 0; i < int'(DEPTH); i++) begin
            bank_n[i] = bank[i];
        end

        unique case (state)
            S_IDLE: begin
                if (wr_en) begin
                    bank_n[wr_addr]   = wr_data;
                    loaded_n[wr_addr] = 1'b1;
                end
                // start is judged against the flags as they were before this cycle's write
                if (start) begin
                    if (&loaded) begin
                        state_n = S_STREAM;
                        idx_n   = '0;
                    end else begin
                        start_err_n = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (wr_en) wr_err_n = 1'b1;
                if (start) start_err_n = 1'b1;
                if (out_ready) begin
                    if (idx == LAST_IDX) begin
                        state_n = S_DONE;
                    end else begin
                        idx_n = ADDR_W'(idx + 1'b1);
                    end
                end
            end
            S_DONE: begin
                if (wr_en) wr_err_n = 1'b1;
                if (start) start_err_n = 1'b1;
                loaded_n = '0;
                state_n  = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        out_valid_n = (state_n == S_STREAM);
        busy_n      = (state_n != S_IDLE);
        done_n      = (state_n == S_DONE);
        out_data_n  = out_valid_n ? bank_n[idx_n] : '0;
        out_index_n = out_valid_n ? idx_n : '0;
    end

    // State, bank and registered outputs; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                bank[i] <= '0;
            end
            loaded    <= '0;
            wr_err    <= 1'b0;
            start_err <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            for (int i = 0; i < int'(DEPTH); i++) begin
                bank[i] <= bank_n[i];
            end
            loaded    <= loaded_n;
            wr_err    <= wr_err_n;
            start_err <= start_err_n;
            out_valid <= out_valid_n;
            busy      <= busy_n;
            done      <= done_n;
            out_data  <= out_data_n;
            out_index <= out_index_n;
        end
    end

endmodule

// File: doc/weight_bank_streamer.md
Name: weight_bank_streamer

Overview:
Receiving end of the ROM-to-network load interface. Captures the DEPTH words written by the ROM loader (write strobe plus slot address plus 32-bit data) into a local register bank. On the loader's one-cycle start pulse, it streams the captured words in slot order to the network datapath over a valid/ready handshake, then pulses done. Sits between the ROM loader and the neuron unit / network controller.

Parameters:
WORD_W, 32, data word width
ADDR_W, 2, slot address width
DEPTH, 4, number of slots; must equal 2**ADDR_W

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  write strobe from loader; one write per cycle while high
wr_addr  in  ADDR_W  slot written when wr_en=1
wr_data  in  WORD_W  data written when wr_en=1
start  in  1  one-cycle start pulse from loader
out_valid  out  1  out_data/out_index hold a word for the consumer
out_ready  in  1  consumer accepts the word when out_valid&&out_ready
out_data  out  WORD_W  current streamed word
out_index  out  ADDR_W  slot index of out_data
busy  out  1  high while STREAM or DONE
done  out  1  one-cycle pulse after the last word transfers
loaded  out  DEPTH  per-slot written flags
wr_err  out  1  sticky: write arrived while busy
start_err  out  1  sticky: start rejected (busy, or bank not fully loaded)

Behaviour:
- Reset (synchronous, wins over all inputs):
  - state=IDLE, idx=0, bank cleared to 0.
  - out_valid=0, out_data=0, out_index=0, busy=0, done=0, loaded=0, wr_err=0, start_err=0.
  - Reset mid-stream aborts immediately. There is no done pulse.
- States: IDLE, STREAM, DONE. All outputs are Moore outputs (derived from registers only). out_data=bank[idx] and out_index=idx while in STREAM; both are 0 otherwise.
- IDLE:
  - wr_en=1 at edge: bank[wr_addr]<=wr_data and loaded[wr_addr]<=1. Rewriting a slot overwrites it; the flag stays 1.
  - start=1 at edge and loaded (pre-edge value) all ones: go to STREAM, idx<=0.
  - start=1 and loaded not all ones: stay in IDLE and set start_err.
  - Simultaneous wr_en and start: the write is performed. start is judged against the pre-write loaded. If start is accepted, the first streamed word reflects the same-cycle write.
- STREAM:
  - out_valid=1, busy=1.
  - Transfer when out_ready=1 at an edge. If idx<DEPTH-1, idx<=idx+1. If idx=DEPTH-1, go to DONE.
  - With out_ready=0, out_data/out_index/out_valid hold stable. There is no timeout.
  - wr_en=1: write ignored (bank and loaded unchanged); wr_err<=1.
  - start=1: ignored; start_err<=1.
- DONE (exactly one cycle):
  - done=1, busy=1, out_valid=0.
  - loaded<=0; bank contents retained. Next state is IDLE.
  - wr_en or start in DONE is treated as in STREAM (ignored, error flag set).
- Latency: start sampled at edge N gives out_valid high from cycle N+1. With out_ready tied 1, words 0..3 occupy cycles N+1..N+4, done is high in cycle N+5, and the block is in IDLE in cycle N+6.
- idx counter is ADDR_W bits and never wraps within a stream; the last-word compare is against DEPTH-1.
- wr_err and start_err clear only on reset.

Test Plan:
1. Load and stream: reset; write 0xAAAA0000, 0x11111111, 0x22222222, 0x33333333 to slots 0..3 with one idle cycle between writes; loaded=4'b1111; start pulse, out_ready=1 -> out_index 0,1,2,3 with those data on four consecutive cycles, done one cycle later, loaded=0, busy low after done, no error flags.
2. Backpressure: same load; out_ready low for 3 cycles at index 1 and again at index 3 -> out_data holds 0x11111111, then 0x33333333, unchanged while stalled; done only after the index-3 handshake; total stream length 4+6 cycles.
3. Incomplete bank: write slots 0,1,3 only; start -> remains IDLE, out_valid never rises, start_err=1. Write slot 2 and start again -> full stream occurs; start_err stays 1.
4. Writes and start while busy: during STREAM, assert wr_en to slot 0 with 0xDEADBEEF and pulse start -> streamed slot 0 value unchanged, wr_err=1, start_err=1, stream completes normally.
5. Simultaneous write/start: after slots 1..3 loaded and slot 0 previously loaded with 0x5, same-cycle wr_en (slot 0, 0x77) and start -> stream accepted, out_data at index 0 = 0x77.
6. Reset mid-stream: assert reset at index 2 -> next cycle all outputs 0, loaded=0, bank=0, no done pulse; a new full load and start streams correctly.
